// File: rtl/clock_divider_pkg.sv
// Shared constants for the core clock divider and countdown timer.
// Countdown state encodings and default half-periods live here.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        DISABLED = 2'd2,
        EXPIRED  = 2'd3
    } countdown_state_t;

    localparam int unsigned DEFAULT_FAST_HALF_PERIOD = 32'd2;
    localparam int unsigned DEFAULT_SLOW_HALF_PERIOD = 32'd50_000_000;
    localparam int unsigned DEFAULT_COUNT_WIDTH      = 32'd16;

    // Bits needed to count 0 .. max_count-1, never narrower than one bit.
    function automatic int unsigned counter_width(input int unsigned max_count);
        int unsigned width;
        if (max_count > 32'd1) begin
            width = $clog2(max_count);
        end else begin
            width = 32'd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/frequency_divider.sv
// Free-running 50% duty divider of clock_100mhz for the core clock mux.
// The half-period is latched only on a toggle, so a mode change never yields a short phase.
module frequency_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned FAST_HALF_PERIOD = DEFAULT_FAST_HALF_PERIOD,
    parameter int unsigned SLOW_HALF_PERIOD = DEFAULT_SLOW_HALF_PERIOD
) (
    input  logic clock_100mhz,
    input  logic reset_button,
    input  logic slow_mode,
    output logic clock_divided
);

    localparam int unsigned DIV_WIDTH = counter_width(SLOW_HALF_PERIOD);
    localparam logic [DIV_WIDTH-1:0] FAST_LAST = DIV_WIDTH'(FAST_HALF_PERIOD - 32'd1);
    localparam logic [DIV_WIDTH-1:0] SLOW_LAST = DIV_WIDTH'(SLOW_HALF_PERIOD - 32'd1);

    // half_last_r holds half_period-1 so the terminal compare needs no subtractor.
    logic [DIV_WIDTH-1:0] div_count_r;
    logic [DIV_WIDTH-1:0] div_count_next_s;
    logic [DIV_WIDTH-1:0] half_last_r;
    logic [DIV_WIDTH-1:0] half_last_next_s;
    logic                 clock_divided_r;
    logic                 clock_divided_next_s;
    logic                 toggle_s;

    // Next-state logic: count up, or on the terminal count clear, toggle and relatch the mode.
    always_comb begin
        toggle_s             = (div_count_r == half_last_r);
        div_count_next_s     = div_count_r + DIV_WIDTH'(1'b1);
        half_last_next_s     = half_last_r;
        clock_divided_next_s = clock_divided_r;
        if (toggle_s) begin
            div_count_next_s     = {DIV_WIDTH{1'b0}};
            clock_divided_next_s = ~clock_divided_r;
            if (slow_mode) begin
                half_last_next_s = SLOW_LAST;
            end else begin
                half_last_next_s = FAST_LAST;
            end
        end else begin
            div_count_next_s = div_count_r + DIV_WIDTH'(1'b1);
        end
    end

    // Divider state registers.
    always_ff @(posedge clock_100mhz or posedge reset_button) begin
        if (reset_button) begin
            div_count_r     <= {DIV_WIDTH{1'b0}};
            half_last_r     <= SLOW_LAST;
            clock_divided_r <= 1'b0;
        end else begin
            div_count_r     <= div_count_next_s;
            half_last_r     <= half_last_next_s;
            clock_divided_r <= clock_divided_next_s;
        end
    end

    assign clock_divided = clock_divided_r;

endmodule

// File: rtl/clock_divider.sv
// Core clock divider plus core-cycle countdown timer feeding clock_control.
// Define CLOCK_COUNTDOWN_EN to build the countdown; otherwise only the divider is built.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int unsigned FAST_HALF_PERIOD = DEFAULT_FAST_HALF_PERIOD,
    parameter int unsigned SLOW_HALF_PERIOD = DEFAULT_SLOW_HALF_PERIOD,
    parameter int unsigned COUNT_WIDTH      = DEFAULT_COUNT_WIDTH
) (
    input  logic                   clock_100mhz,
    input  logic                   reset_button,
    input  logic                   slow_mode,
    input  logic                   core_clock,
    input  logic                   countdown_reset,
    input  logic [COUNT_WIDTH-1:0] countdown_value,
    output logic                   clock_divided,
    output logic                   countdown_timed_up,
    output logic [COUNT_WIDTH-1:0] countdown_remaining
);

    frequency_divider #(
        .FAST_HALF_PERIOD (FAST_HALF_PERIOD),
        .SLOW_HALF_PERIOD (SLOW_HALF_PERIOD)
    ) u_frequency_divider (
        .clock_100mhz  (clock_100mhz),
        .reset_button  (reset_button),
        .slow_mode     (slow_mode),
        .clock_divided (clock_divided)
    );

`ifdef CLOCK_COUNTDOWN_EN

    countdown_state_t       state_r;
    countdown_state_t       state_next_s;
    logic                   core_q_r;
    logic                   core_rise_s;
    logic [COUNT_WIDTH-1:0] remaining_r;
    logic [COUNT_WIDTH-1:0] remaining_next_s;
    logic                   timed_up_r;
    logic                   timed_up_next_s;

    assign core_rise_s = core_clock & ~core_q_r;

    // Countdown next-state: a reload overrides everything, including a coincident core edge.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        timed_up_next_s  = 1'b0;
        if (countdown_reset) begin
            state_next_s     = HOLD;
            remaining_next_s = countdown_value;
        end else begin
            case (state_r)
                HOLD: begin
                    if (remaining_r == {COUNT_WIDTH{1'b0}}) begin
                        state_next_s = DISABLED;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                RUN: begin
                    if (core_rise_s) begin
                        if (remaining_r == COUNT_WIDTH'(1'b1)) begin
                            remaining_next_s = {COUNT_WIDTH{1'b0}};
                            timed_up_next_s  = 1'b1;
                            state_next_s     = EXPIRED;
                        end else begin
                            remaining_next_s = remaining_r - COUNT_WIDTH'(1'b1);
                        end
                    end else begin
                        state_next_s = RUN;
                    end
                end
                DISABLED: state_next_s = DISABLED;
                EXPIRED:  state_next_s = EXPIRED;
                default:  state_next_s = HOLD;
            endcase
        end
    end

    // Countdown registers; the expiry pulse is registered so it lasts exactly one cycle.
    always_ff @(posedge clock_100mhz or posedge reset_button) begin
        if (reset_button) begin
            state_r     <= HOLD;
            remaining_r <= {COUNT_WIDTH{1'b0}};
            timed_up_r  <= 1'b0;
            core_q_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            timed_up_r  <= timed_up_next_s;
            core_q_r    <= core_clock;
        end
    end

    assign countdown_timed_up  = timed_up_r;
    assign countdown_remaining = remaining_r;

`else

    logic unused_countdown_inputs_s;
    assign unused_countdown_inputs_s = ^{core_clock, countdown_reset, countdown_value};

    assign countdown_timed_up  = 1'b0;
    assign countdown_remaining = {COUNT_WIDTH{1'b0}};

`endif

endmodule
